// File: rtl/user_extern_requester.sv
// Initiator for a VNP4 user extern: takes one request, pulses it to the extern,
// waits for the reply (or gives up after TIMEOUT_CYCLES) and offers the response downstream.
module user_extern_requester #(
    parameter int REQ_W          = 64,
    parameter int RSP_W          = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [REQ_W-1:0] req_data,
    output logic             user_extern_out_valid,
    output logic [REQ_W-1:0] user_extern_out,
    input  logic             user_extern_in_valid,
    input  logic [RSP_W-1:0] user_extern_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RSP_W-1:0] rsp_data,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [15:0]      timeout_count,
    output logic [15:0]      stray_count
);
    localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit HAS_TIMEOUT = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state                 <= IDLE;
            timer                 <= '0;
            req_ready             <= 1'b0;
            user_extern_out_valid <= 1'b0;
            user_extern_out       <= '0;
            rsp_valid             <= 1'b0;
            rsp_data              <= '0;
            rsp_timeout           <= 1'b0;
            busy                  <= 1'b0;
            timeout_count         <= '0;
            stray_count           <= '0;
        end else begin
            // Replies outside WAIT (including late ones after a timeout) are dropped but counted.
            if (user_extern_in_valid && state != WAIT && stray_count != 16'hFFFF)
                stray_count <= stray_count + 16'd1;

            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready             <= 1'b0;
                        busy                  <= 1'b1;
                        user_extern_out_valid <= 1'b1;
                        user_extern_out       <= req_data;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    user_extern_out_valid <= 1'b0;
                    user_extern_out       <= '0;
                    timer                 <= '0;
                    state                 <= WAIT;
                end
                WAIT: begin
                    // A reply landing in the final WAIT cycle beats the timeout.
                    if (user_extern_in_valid) begin
                        rsp_data    <= user_extern_in;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= HOLD;
                    end else if (HAS_TIMEOUT && timer == TIMER_LAST) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        if (timeout_count != 16'hFFFF)
                            timeout_count <= timeout_count + 16'd1;
                        state       <= HOLD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_user_extern_requester.sv
// Bench for user_extern_requester: a divider-extern stub, directed requests and a
// scoreboard monitor that checks every response handshake against queued expectations.
module tb_user_extern_requester;
    logic        aclk;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_data;
    logic        user_extern_out_valid;
    logic [63:0] user_extern_out;
    logic        user_extern_in_valid;
    logic [63:0] user_extern_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] timeout_count;
    logic [15:0] stray_count;

    typedef struct {
        logic [63:0] data;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   stub_delay;
    int   inject_req;
    int   inject_done;

    user_extern_requester #(
        .REQ_W(64),
        .RSP_W(64),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_data             (req_data),
        .user_extern_out_valid(user_extern_out_valid),
        .user_extern_out      (user_extern_out),
        .user_extern_in_valid (user_extern_in_valid),
        .user_extern_in       (user_extern_in),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_data             (rsp_data),
        .rsp_timeout          (rsp_timeout),
        .busy                 (busy),
        .timeout_count        (timeout_count),
        .stray_count          (stray_count)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Divider extern: request {divisor, dividend}, reply {remainder, quotient}.
    function automatic logic [63:0] divide(input logic [63:0] r);
        logic [31:0] n;
        logic [31:0] d;
        n = r[31:0];
        d = r[63:32];
        if (d == 32'd0)
            return {n, 32'hFFFF_FFFF};
        return {n % d, n / d};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Extern stub: replies stub_delay cycles after sampling the request; 0 = silent.
    initial begin
        int          pend;
        logic [63:0] held;
        pend = 0;
        held = '0;
        inject_done = 0;
        user_extern_in_valid = 1'b0;
        user_extern_in = '0;
        forever begin
            @(negedge aclk);
            user_extern_in_valid = 1'b0;
            user_extern_in = '0;
            if (inject_done != inject_req) begin
                inject_done++;
                user_extern_in_valid = 1'b1;
                user_extern_in = 64'hDEAD_BEEF_0000_0001;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    user_extern_in_valid = 1'b1;
                    user_extern_in = held;
                end
            end
            if (user_extern_out_valid && stub_delay > 0) begin
                pend = stub_delay;
                held = divide(user_extern_out);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            #1;
            if (!areset && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: got %h, want no response", rsp_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e.to});
                end
            end
        end
    end

    // Issues one request from a negedge; returns at the negedge just after acceptance.
    task automatic applyStimulus(input logic [63:0] data);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("req_ready_before_issue", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_data  = data;
        @(negedge aclk);
        req_valid = 1'b0;
        req_data  = '0;
        checkOutput("out_valid_pulse", {63'd0, user_extern_out_valid}, 64'd1);
        checkOutput("out_word", user_extern_out, data);
    endtask

    task automatic waitResponse(output int latency);
        @(negedge aclk);
        checkOutput("out_valid_low", {63'd0, user_extern_out_valid}, 64'd0);
        checkOutput("out_word_zero", user_extern_out, 64'd0);
        latency = 2;
        while (!rsp_valid && latency < 40) begin
            @(negedge aclk);
            latency++;
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while ((busy || !req_ready) && n < 50);
        checkOutput("idle_reached", {63'd0, (busy || !req_ready)}, 64'd0);
    endtask

    initial begin
        int   lat;
        logic saw;
        checks = 0;
        errors = 0;
        inject_req = 0;
        areset = 1'b1;
        req_valid = 1'b0;
        req_data = '0;
        rsp_ready = 1'b1;
        stub_delay = 1;
        repeat (2) @(negedge aclk);
        checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("reset_out_valid", {63'd0, user_extern_out_valid}, 64'd0);
        checkOutput("reset_counts", {32'd0, timeout_count, stray_count}, 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("req_ready_after_reset", {63'd0, req_ready}, 64'd1);

        // Divider answer 10 / 3.
        sb.push_back('{64'h00000001_00000003, 1'b0});
        applyStimulus(64'h00000003_0000000A);
        waitResponse(lat);
        checkOutput("t1_latency", 64'(lat), 64'd3);
        checkOutput("t1_busy", {63'd0, busy}, 64'd1);
        waitIdle();

        // Divide by zero.
        sb.push_back('{64'h00000007_FFFFFFFF, 1'b0});
        applyStimulus(64'h00000000_00000007);
        waitResponse(lat);
        checkOutput("t2_latency", 64'(lat), 64'd3);
        waitIdle();

        // Back-pressure in HOLD, with the next request already waiting.
        rsp_ready = 1'b0;
        sb.push_back('{64'h00000001_00000004, 1'b0});
        applyStimulus(64'h00000002_00000009);
        waitResponse(lat);
        checkOutput("t3_latency", 64'(lat), 64'd3);
        sb.push_back('{64'h00000002_00000003, 1'b0});
        req_valid = 1'b1;
        req_data  = 64'h00000005_00000011;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checkOutput("t3_hold_valid", {63'd0, rsp_valid}, 64'd1);
            checkOutput("t3_hold_data", rsp_data, 64'h00000001_00000004);
            checkOutput("t3_hold_req_ready", {63'd0, req_ready}, 64'd0);
            checkOutput("t3_hold_no_out", {63'd0, user_extern_out_valid}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        checkOutput("t3_rsp_valid_fell", {63'd0, rsp_valid}, 64'd0);
        checkOutput("t3_req_ready_back", {63'd0, req_ready}, 64'd1);
        @(negedge aclk);
        req_valid = 1'b0;
        req_data  = '0;
        checkOutput("t3_next_accepted", {63'd0, user_extern_out_valid}, 64'd1);
        checkOutput("t3_next_word", user_extern_out, 64'h00000005_00000011);
        waitIdle();

        // Reply on the final WAIT cycle wins over the timeout.
        stub_delay = 4;
        sb.push_back('{64'h00000000_00000003, 1'b0});
        applyStimulus(64'h00000004_0000000C);
        waitResponse(lat);
        checkOutput("t5_latency", 64'(lat), 64'd6);
        checkOutput("t5_timeout_count", {48'd0, timeout_count}, 64'd0);
        waitIdle();

        // Silent extern times out, then replies late.
        stub_delay = 0;
        sb.push_back('{64'd0, 1'b1});
        applyStimulus(64'h00000003_00000009);
        waitResponse(lat);
        checkOutput("t4_latency", 64'(lat), 64'd6);
        checkOutput("t4_timeout_count", {48'd0, timeout_count}, 64'd1);
        checkOutput("t4_stray_before", {48'd0, stray_count}, 64'd0);
        @(negedge aclk);
        inject_req++;
        repeat (3) @(negedge aclk);
        checkOutput("t4_stray_count", {48'd0, stray_count}, 64'd1);
        waitIdle();

        // Reset in the middle of WAIT abandons the transaction.
        applyStimulus(64'h00000003_0000000A);
        repeat (2) @(negedge aclk);
        checkOutput("t6_busy_in_wait", {63'd0, busy}, 64'd1);
        #2 areset = 1'b1;
        #1;
        checkOutput("t6_busy_cleared", {63'd0, busy}, 64'd0);
        checkOutput("t6_req_ready_cleared", {63'd0, req_ready}, 64'd0);
        checkOutput("t6_rsp_valid_cleared", {63'd0, rsp_valid}, 64'd0);
        checkOutput("t6_counts_cleared", {32'd0, timeout_count, stray_count}, 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        inject_req++;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            if (rsp_valid)
                saw = 1'b1;
        end
        checkOutput("t6_no_rsp", {63'd0, saw}, 64'd0);
        checkOutput("t6_stray_count", {48'd0, stray_count}, 64'd1);
        checkOutput("t6_timeout_count", {48'd0, timeout_count}, 64'd0);
        checkOutput("t6_req_ready", {63'd0, req_ready}, 64'd1);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
